rle_dec: RTL
============

# rle_dec

Run-length decoder: the inverse of the team's RLE encoder. It reads 24-bit run words from the input-side FIFO (bit 23 = bit value, bits 22:0 = run length), re-expands each run into a bit stream, and packs the bits into bytes written to the output-side FIFO. It reproduces the original byte stream bit-for-bit, with LSB-first bit order per byte, and flushes a zero-padded partial byte at end of stream.

## Interface
- COUNT_W, 23: run-length field width; the input word is COUNT_W+1 bits.
- BYTE_W, 8: output byte width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- recv_ready  in  1  input FIFO not empty.
- send_ready  in  1  output FIFO not full.
- in_data  in  COUNT_W+1  run word; [COUNT_W] = bit value, [COUNT_W-1:0] = run length.
- end_of_stream  in  1  no further run words will arrive once the input FIFO drains.
- rd_req  out  1  input FIFO read request, one-cycle pulse.
- wr_req  out  1  output FIFO write request, one-cycle pulse.
- out_data  out  BYTE_W  packed output byte.
- done  out  1  sticky; stream fully decoded and flushed.

## Operation
- States and transitions:
  - IDLE -> REQ_IN.
  - REQ_IN:
    - recv_ready -> WAIT_IN.
    - Otherwise, end_of_stream with fill>0 -> FLUSH.
    - Otherwise, end_of_stream with fill=0 -> DONE.
    - Otherwise stay.
  - WAIT_IN -> LOAD.
  - LOAD latches value_bit and run_cnt from in_data.
    - run_cnt=0 -> REQ_IN: zero-length word, no bits emitted.
    - Otherwise -> EMIT.
  - EMIT emits one bit per cycle: shift_buf <= {value_bit, shift_buf[BYTE_W-1:1]}, run_cnt--, fill++.
    - If fill reaches BYTE_W -> REQ_OUT.
    - Else if run_cnt reaches 0 -> REQ_IN.
    - Else stay.
  - REQ_OUT: waits for send_ready, then -> WAIT_OUT.
  - WAIT_OUT -> back to EMIT if run_cnt>0, else REQ_IN. On leaving, fill is cleared.
  - FLUSH shifts zeros in, one per cycle, until fill=BYTE_W, then -> REQ_OUT. After that write, -> DONE.
  - DONE is terminal until reset.
- Bit order: the first decoded bit of a byte lands in out_data[0]. A partial byte with k bits occupies [k-1:0] and the upper bits are 0.
- Runs span byte boundaries freely. A run longer than the remaining fill continues after the write.
- run_cnt is COUNT_W bits and counts down; the maximum run is 2^COUNT_W-1, with no overflow path.
- end_of_stream is only acted on in REQ_IN with recv_ready low. If recv_ready and end_of_stream are both high, the read takes priority.

## Timing
- Reset values: rd_req=0, wr_req=0, out_data=0, done=0, state=IDLE, fill=0, run_cnt=0.
- Asserting rst mid-operation aborts at once. Any partial byte is discarded, and no further FIFO requests are issued.
- rd_req:
  - Registered, high for exactly the one cycle after REQ_IN sees recv_ready.
  - in_data is sampled two clocks after rd_req rises (LOAD).
- wr_req:
  - Registered, high for exactly the one cycle after REQ_OUT sees send_ready.
  - out_data is stable from the cycle wr_req rises until the next EMIT/FLUSH shift.
- Latency per run word: 3 cycles of fetch, then 1 cycle per bit, plus 2 cycles per completed byte.
- A full byte from a single run of 8 takes word-available to wr_req = 12 cycles.
- done rises the cycle after the final wr_req is issued (or directly from REQ_IN if fill=0) and stays high.
- No output byte is written while send_ready=0; the decoder stalls in REQ_OUT indefinitely.

## Structure
- rle_pkg: state enum; COUNT_W/BYTE_W defaults, shared with rle_enc; word field index constants (VAL_BIT = COUNT_W).
- One natural sub-module: rle_bit_packer.
  - Shift register plus fill counter.
  - Inputs: shift_en, bit_in, clear.
  - Outputs: byte, full.
  - Used by both EMIT and FLUSH.
- The top level holds the FSM and run counter.

## Test plan
- Words {1,8}, then end_of_stream: exactly one write, out_data=8'hFF, then done=1, with no extra write.
- Words {0,3},{1,5}, then end_of_stream: one write of 8'hF8. A second word {1,4} before end of stream instead gives 8'hF8, 8'h0F.
- Word {1,20}, then end_of_stream: writes 8'hFF, 8'hFF, then flush 8'h0F; done after the third wr_req.
- Zero-length word {1,0} between {0,4} and {1,4}: output is 8'hF0, with no bit emitted for the zero word.
- send_ready held low for 10 cycles at the first byte: wr_req stays 0 and out_data is held. Write occurs 1 cycle after send_ready rises; no data loss.
- rst pulled low during EMIT of {1,100}: all outputs return to reset values asynchronously. After release, a fresh {0,8} gives 8'h00.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: field widths,
// run-word layout and the decoder state encoding.
package rle_pkg;

   localparam int COUNT_W_DEF = 23;
   localparam int BYTE_W_DEF  = 8;
   localparam int VAL_BIT_DEF = COUNT_W_DEF;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ_IN,
      ST_WAIT_IN,
      ST_LOAD,
      ST_EMIT,
      ST_REQ_OUT,
      ST_WAIT_OUT,
      ST_FLUSH,
      ST_DONE
   } dec_state_e;

endpackage

// File: rtl/rle_bit_packer.sv
// LSB-first bit packer: each shift inserts at the MSB, so after BYTE_W shifts
// the first bit sits in bit 0. The fill counter tracks bits in the current byte.
module rle_bit_packer
   import rle_pkg::*;
#(
   parameter int BYTE_W = BYTE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic              bit_in,
   input  logic              clear,
   output logic [BYTE_W-1:0] byte_out,
   output logic              full,
   output logic              empty
);

   localparam int FILL_W = $clog2(BYTE_W + 1);

   logic [BYTE_W-1:0] shift_buf_q, shift_buf_d;
   logic [FILL_W-1:0] fill_q, fill_d;

   always_comb begin
      shift_buf_d = shift_buf_q;
      fill_d      = (clear ? '0 : fill_q) + FILL_W'(shift_en);
      if (shift_en) begin
         shift_buf_d = {bit_in, shift_buf_q[BYTE_W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_buf_q <= '0;
         fill_q      <= '0;
      end else begin
         shift_buf_q <= shift_buf_d;
         fill_q      <= fill_d;
      end
   end

   // full flags the shift that completes the byte, so the FSM can leave on that same edge
   assign full     = shift_en && (fill_q == FILL_W'(BYTE_W - 1));
   assign empty    = (fill_q == '0);
   assign byte_out = shift_buf_q;

endmodule

// File: rtl/rle_dec.sv
// Run-length decoder: fetches {value, length} words, re-expands each run into
// bits and packs them LSB-first into bytes, flushing a zero-padded tail byte.
module rle_dec
   import rle_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEF,
   parameter int BYTE_W  = BYTE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               recv_ready,
   input  logic               send_ready,
   input  logic [COUNT_W:0]   in_data,
   input  logic               end_of_stream,
   output logic               rd_req,
   output logic               wr_req,
   output logic [BYTE_W-1:0]  out_data,
   output logic               done
);

   localparam int VAL_BIT = COUNT_W;

   dec_state_e         state_q, state_d;
   logic [COUNT_W-1:0] run_cnt_q, run_cnt_d;
   logic               value_bit_q, value_bit_d;
   logic               flushing_q, flushing_d;
   logic               rd_req_q, rd_req_d;
   logic               wr_req_q, wr_req_d;
   logic               done_q, done_d;

   logic shift_en, bit_in, clear, full, empty;

   rle_bit_packer #(.BYTE_W(BYTE_W)) u_packer (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .bit_in   (bit_in),
      .clear    (clear),
      .byte_out (out_data),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      state_d     = state_q;
      run_cnt_d   = run_cnt_q;
      value_bit_d = value_bit_q;
      flushing_d  = flushing_q;
      rd_req_d    = 1'b0;
      wr_req_d    = 1'b0;
      shift_en    = 1'b0;
      bit_in      = 1'b0;
      clear       = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_REQ_IN;

         // A pending word always wins over end_of_stream
         ST_REQ_IN: begin
            if (recv_ready) begin
               rd_req_d = 1'b1;
               state_d  = ST_WAIT_IN;
            end else if (end_of_stream) begin
               if (!empty) begin
                  flushing_d = 1'b1;
                  state_d    = ST_FLUSH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_WAIT_IN: state_d = ST_LOAD;

         ST_LOAD: begin
            value_bit_d = in_data[VAL_BIT];
            run_cnt_d   = in_data[COUNT_W-1:0];
            state_d     = (in_data[COUNT_W-1:0] == '0) ? ST_REQ_IN : ST_EMIT;
         end

         ST_EMIT: begin
            shift_en  = 1'b1;
            bit_in    = value_bit_q;
            run_cnt_d = run_cnt_q - COUNT_W'(1);
            if (full) begin
               state_d = ST_REQ_OUT;
            end else if (run_cnt_q == COUNT_W'(1)) begin
               state_d = ST_REQ_IN;
            end
         end

         ST_REQ_OUT: begin
            if (send_ready) begin
               wr_req_d = 1'b1;
               state_d  = ST_WAIT_OUT;
            end
         end

         // Byte has been handed off; resume the current run if it has bits left
         ST_WAIT_OUT: begin
            clear = 1'b1;
            if (flushing_q) begin
               state_d = ST_DONE;
            end else if (run_cnt_q != '0) begin
               state_d = ST_EMIT;
            end else begin
               state_d = ST_REQ_IN;
            end
         end

         ST_FLUSH: begin
            shift_en = 1'b1;
            if (full) begin
               state_d = ST_REQ_OUT;
            end
         end

         ST_DONE: state_d = ST_DONE;

         default: state_d = ST_IDLE;
      endcase

      done_d = done_q | (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         run_cnt_q   <= '0;
         value_bit_q <= 1'b0;
         flushing_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         wr_req_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         value_bit_q <= value_bit_d;
         flushing_q  <= flushing_d;
         rd_req_q    <= rd_req_d;
         wr_req_q    <= wr_req_d;
         done_q      <= done_d;
      end
   end

   assign rd_req = rd_req_q;
   assign wr_req = wr_req_q;
   assign done   = done_q;

endmodule
